// File: rtl/hcordic_fp_pkg.sv
// Shared single-precision field widths, special constants and the per-stage
// sideband record for the constant-add pipeline.
package hcordic_fp_pkg;

    localparam int unsigned FP_W    = 32;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned WM_W    = 27;
    localparam int unsigned SUM_W   = 28;
    localparam int unsigned LZ_W    = 5;
    localparam int unsigned XEXP_W  = 10;

    localparam logic [FP_W-1:0] QNAN = 32'h7fc00000;
    localparam logic [FP_W-1:0] INF  = 32'h7f800000;

    // Sideband field widths; the top-level width parameters must not exceed these.
    localparam int unsigned SB_Z_W   = 32;
    localparam int unsigned SB_OP_W  = 4;
    localparam int unsigned SB_TAG_W = 8;

    typedef struct packed {
        logic                valid;
        logic [SB_Z_W-1:0]   z;
        logic [SB_OP_W-1:0]  opcode;
        logic [SB_TAG_W-1:0] tag;
    } sideband_t;

endpackage

// File: rtl/fp_normalise.sv
// Leading-zero count of the working mantissa and the matching left shift,
// so the leading one lands in the hidden-bit position.
module fp_normalise
    import hcordic_fp_pkg::*;
(
    input  logic [WM_W-1:0] i_mant,
    output logic [WM_W-1:0] o_mant_c,
    output logic [LZ_W-1:0] o_lz_c
);

    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        o_lz_c = LZ_W'(WM_W);
        for (int i = 0; i < int'(WM_W); i++) begin
            if (i_mant[i]) begin
                o_lz_c = LZ_W'(int'(WM_W) - 1 - i);
            end
        end
    end

    assign o_mant_c = i_mant << o_lz_c;

endmodule

// File: rtl/const_add_pipe.sv
// Five-stage single-precision adder of a fixed constant with a valid/ready
// elastic pipeline and pass-through sideband (z, opcode, tag).
module const_add_pipe
    import hcordic_fp_pkg::*;
#(
    parameter logic [31:0] CONST_A = 32'h3f800000,
    parameter int unsigned PASS_W  = 32,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned TAG_W   = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_b,
    input  logic              in_sub,
    input  logic [PASS_W-1:0] in_z,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_sum,
    output logic [PASS_W-1:0] out_z,
    output logic [OP_W-1:0]   out_opcode,
    output logic [TAG_W-1:0]  out_tag
);

    logic w_advance;
    assign w_advance = out_ready | ~out_valid;
    assign in_ready  = w_advance;

    // ---------------- stage 1: special-case detect ----------------
    logic [31:0]      w_a;
    logic             w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
    logic             w_special;
    logic [31:0]      w_spec_val;
    sideband_t        w_in_sb;

    assign w_a      = {CONST_A[31] ^ in_sub, CONST_A[30:0]};
    assign w_a_nan  = (&w_a[30:23]) & (|w_a[22:0]);
    assign w_a_inf  = (&w_a[30:23]) & ~(|w_a[22:0]);
    assign w_a_zero = ~(|w_a[30:23]);
    assign w_b_nan  = (&in_b[30:23]) & (|in_b[22:0]);
    assign w_b_inf  = (&in_b[30:23]) & ~(|in_b[22:0]);
    assign w_b_zero = ~(|in_b[30:23]);

    // Denormals fall into the zero cases since only the exponent is tested.
    always_comb begin
        w_special  = 1'b1;
        w_spec_val = QNAN;
        if (w_a_nan || w_b_nan) begin
            w_spec_val = QNAN;
        end else if (w_a_inf && w_b_inf) begin
            w_spec_val = (w_a[31] == in_b[31]) ? w_a : QNAN;
        end else if (w_a_inf) begin
            w_spec_val = w_a;
        end else if (w_b_inf) begin
            w_spec_val = in_b;
        end else if (w_a_zero && w_b_zero) begin
            w_spec_val = {w_a[31] & in_b[31], 31'b0};
        end else if (w_a_zero) begin
            w_spec_val = in_b;
        end else if (w_b_zero) begin
            w_spec_val = w_a;
        end else begin
            w_special = 1'b0;
        end
    end

    always_comb begin
        w_in_sb        = '0;
        w_in_sb.valid  = in_valid;
        w_in_sb.z      = SB_Z_W'(in_z);
        w_in_sb.opcode = SB_OP_W'(in_opcode);
        w_in_sb.tag    = SB_TAG_W'(in_tag);
    end

    sideband_t   r_s1_sb;
    logic        r_s1_special, r_s1_sign_a, r_s1_sign_b;
    logic [31:0] r_s1_spec_val;
    logic [7:0]  r_s1_exp_a, r_s1_exp_b;
    logic [23:0] r_s1_man_a, r_s1_man_b;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_sb       <= '0;
            r_s1_special  <= 1'b0;
            r_s1_spec_val <= '0;
            r_s1_sign_a   <= 1'b0;
            r_s1_sign_b   <= 1'b0;
            r_s1_exp_a    <= '0;
            r_s1_exp_b    <= '0;
            r_s1_man_a    <= '0;
            r_s1_man_b    <= '0;
        end else if (w_advance) begin
            r_s1_sb       <= w_in_sb;
            r_s1_special  <= w_special;
            r_s1_spec_val <= w_spec_val;
            r_s1_sign_a   <= w_a[31];
            r_s1_sign_b   <= in_b[31];
            r_s1_exp_a    <= w_a[30:23];
            r_s1_exp_b    <= in_b[30:23];
            r_s1_man_a    <= {1'b1, w_a[22:0]};
            r_s1_man_b    <= {1'b1, in_b[22:0]};
        end
    end

    // ---------------- stage 2: align ----------------
    logic            w_a_big, w_big_sign;
    logic [7:0]      w_exp_big, w_diff;
    logic [23:0]     w_man_big, w_man_small;
    logic [WM_W-1:0] w_small_ext, w_shifted, w_small_al;
    logic            w_sticky;

    assign w_a_big     = {r_s1_exp_a, r_s1_man_a} >= {r_s1_exp_b, r_s1_man_b};
    assign w_big_sign  = w_a_big ? r_s1_sign_a : r_s1_sign_b;
    assign w_exp_big   = w_a_big ? r_s1_exp_a : r_s1_exp_b;
    assign w_man_big   = w_a_big ? r_s1_man_a : r_s1_man_b;
    assign w_man_small = w_a_big ? r_s1_man_b : r_s1_man_a;
    assign w_diff      = w_a_big ? (r_s1_exp_a - r_s1_exp_b) : (r_s1_exp_b - r_s1_exp_a);
    assign w_small_ext = {w_man_small, 3'b000};

    // Bits shifted past the working width collapse into the sticky bit.
    always_comb begin
        w_shifted = '0;
        w_sticky  = 1'b1;
        if (w_diff < 8'(WM_W)) begin
            w_shifted = w_small_ext >> w_diff;
            w_sticky  = |(w_small_ext & ~({WM_W{1'b1}} << w_diff));
        end
    end
    assign w_small_al = w_shifted | WM_W'(w_sticky);

    sideband_t       r_s2_sb;
    logic            r_s2_special, r_s2_sign, r_s2_eff_sub;
    logic [31:0]     r_s2_spec_val;
    logic [7:0]      r_s2_exp;
    logic [WM_W-1:0] r_s2_big, r_s2_small;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_sb       <= '0;
            r_s2_special  <= 1'b0;
            r_s2_spec_val <= '0;
            r_s2_sign     <= 1'b0;
            r_s2_eff_sub  <= 1'b0;
            r_s2_exp      <= '0;
            r_s2_big      <= '0;
            r_s2_small    <= '0;
        end else if (w_advance) begin
            r_s2_sb       <= r_s1_sb;
            r_s2_special  <= r_s1_special;
            r_s2_spec_val <= r_s1_spec_val;
            r_s2_sign     <= w_big_sign;
            r_s2_eff_sub  <= r_s1_sign_a ^ r_s1_sign_b;
            r_s2_exp      <= w_exp_big;
            r_s2_big      <= {w_man_big, 3'b000};
            r_s2_small    <= w_small_al;
        end
    end

    // ---------------- stage 3: add ----------------
    logic [SUM_W-1:0] w_sum;
    assign w_sum = r_s2_eff_sub ? ({1'b0, r_s2_big} - {1'b0, r_s2_small})
                                : ({1'b0, r_s2_big} + {1'b0, r_s2_small});

    sideband_t        r_s3_sb;
    logic             r_s3_special, r_s3_sign;
    logic [31:0]      r_s3_spec_val;
    logic [7:0]       r_s3_exp;
    logic [SUM_W-1:0] r_s3_sum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s3_sb       <= '0;
            r_s3_special  <= 1'b0;
            r_s3_spec_val <= '0;
            r_s3_sign     <= 1'b0;
            r_s3_exp      <= '0;
            r_s3_sum      <= '0;
        end else if (w_advance) begin
            r_s3_sb       <= r_s2_sb;
            r_s3_special  <= r_s2_special;
            r_s3_spec_val <= r_s2_spec_val;
            r_s3_sign     <= r_s2_sign;
            r_s3_exp      <= r_s2_exp;
            r_s3_sum      <= w_sum;
        end
    end

    // ---------------- stage 4: normalise ----------------
    logic [WM_W-1:0]   w_norm_mant, w_n_mant;
    logic [LZ_W-1:0]   w_lz;
    logic [XEXP_W-1:0] w_n_exp;

    fp_normalise u_norm (
        .i_mant   (r_s3_sum[WM_W-1:0]),
        .o_mant_c (w_norm_mant),
        .o_lz_c   (w_lz)
    );

    // A carry out of the add shifts right once, folding the lost bit into sticky.
    always_comb begin
        w_n_mant = w_norm_mant;
        w_n_exp  = XEXP_W'(r_s3_exp) - XEXP_W'(w_lz);
        if (r_s3_sum[SUM_W-1]) begin
            w_n_mant = {r_s3_sum[SUM_W-1:2], r_s3_sum[1] | r_s3_sum[0]};
            w_n_exp  = XEXP_W'(r_s3_exp) + XEXP_W'(1);
        end
    end

    sideband_t         r_s4_sb;
    logic              r_s4_special, r_s4_sign, r_s4_zero;
    logic [31:0]       r_s4_spec_val;
    logic [XEXP_W-1:0] r_s4_exp;
    logic [WM_W-1:0]   r_s4_mant;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s4_sb       <= '0;
            r_s4_special  <= 1'b0;
            r_s4_spec_val <= '0;
            r_s4_sign     <= 1'b0;
            r_s4_zero     <= 1'b0;
            r_s4_exp      <= '0;
            r_s4_mant     <= '0;
        end else if (w_advance) begin
            r_s4_sb       <= r_s3_sb;
            r_s4_special  <= r_s3_special;
            r_s4_spec_val <= r_s3_spec_val;
            r_s4_sign     <= r_s3_sign;
            r_s4_zero     <= ~(|r_s3_sum);
            r_s4_exp      <= w_n_exp;
            r_s4_mant     <= w_n_mant;
        end
    end

    // ---------------- stage 5: round / pack ----------------
    logic              w_rup;
    logic [24:0]       w_rmant;
    logic [XEXP_W-1:0] w_r_exp;
    logic [22:0]       w_frac;
    logic [31:0]       w_result;

    assign w_rup   = r_s4_mant[2] & (r_s4_mant[1] | r_s4_mant[0] | r_s4_mant[3]);
    assign w_rmant = {1'b0, r_s4_mant[26:3]} + 25'(w_rup);

    // The exponent is two's complement here: bit 9 set means it went below zero.
    always_comb begin
        w_r_exp = r_s4_exp;
        w_frac  = w_rmant[22:0];
        if (w_rmant[24]) begin
            w_r_exp = r_s4_exp + XEXP_W'(1);
            w_frac  = w_rmant[23:1];
        end
        if (r_s4_special) begin
            w_result = r_s4_spec_val;
        end else if (r_s4_zero) begin
            w_result = '0;
        end else if (w_r_exp[XEXP_W-1] || (w_r_exp == '0)) begin
            w_result = {r_s4_sign, 31'b0};
        end else if (w_r_exp > XEXP_W'(254)) begin
            w_result = {r_s4_sign, INF[30:0]};
        end else begin
            w_result = {r_s4_sign, w_r_exp[7:0], w_frac};
        end
    end

    sideband_t   r_out_sb;
    logic [31:0] r_out_sum;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_sb  <= '0;
            r_out_sum <= '0;
        end else if (w_advance) begin
            r_out_sb  <= r_s4_sb;
            r_out_sum <= w_result;
        end
    end

    assign out_valid  = r_out_sb.valid;
    assign out_sum    = r_out_sum;
    assign out_z      = PASS_W'(r_out_sb.z);
    assign out_opcode = OP_W'(r_out_sb.opcode);
    assign out_tag    = TAG_W'(r_out_sb.tag);

endmodule

// File: tb/tb_const_add_pipe.sv
// Scoreboard bench for const_add_pipe: expected results queued at acceptance,
// popped and compared when the pipeline hands a beat downstream.
module tb_const_add_pipe;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic [31:0] in_z = '0;
    logic [3:0]  in_opcode = '0;
    logic [7:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic [31:0] out_z;
    logic [3:0]  out_opcode;
    logic [7:0]  out_tag;

    const_add_pipe dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .in_z       (in_z),
        .in_opcode  (in_opcode),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_z      (out_z),
        .out_opcode (out_opcode),
        .out_tag    (out_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] b;
        logic        sub;
        logic [31:0] z;
        logic [3:0]  op;
        logic [7:0]  tag;
        logic [31:0] exp_sum;
    } stim_t;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] z;
        logic [3:0]  op;
        logic [7:0]  tag;
        int          step;
    } exp_t;

    stim_t pend[$];
    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    step_no = 0;
    int    last_lat = -1;
    logic  last_in_ready = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Small positive integer to single precision (exact for k < 2^24).
    function automatic logic [31:0] i2f(input int unsigned k);
        int          msb;
        logic [31:0] m;
        msb = 0;
        if (k == 0) return 32'h0;
        for (int i = 0; i < 32; i++) if (k[i]) msb = i;
        m = k << (23 - msb);
        return {1'b0, 8'(127 + msb), m[22:0]};
    endfunction

    task automatic add_stim(input logic [31:0] b, input logic sub, input logic [31:0] exp_sum,
                            input logic [7:0] tag);
        stim_t s;
        s.b = b; s.sub = sub; s.exp_sum = exp_sum; s.tag = tag;
        s.z = $urandom; s.op = 4'($urandom);
        pend.push_back(s);
    endtask

    // One clock: drive at the falling edge, then sample handshakes just after.
    task automatic step(input logic ordy);
        exp_t e;
        @(negedge clock);
        out_ready = ordy;
        if (pend.size() > 0) begin
            in_valid = 1'b1; in_b = pend[0].b; in_sub = pend[0].sub;
            in_z = pend[0].z; in_opcode = pend[0].op; in_tag = pend[0].tag;
        end else begin
            in_valid = 1'b0; in_b = '0; in_sub = 1'b0; in_z = '0; in_opcode = '0; in_tag = '0;
        end
        #1;
        last_in_ready = in_ready;
        if (in_valid && in_ready) begin
            e.sum = pend[0].exp_sum; e.z = pend[0].z; e.op = pend[0].op;
            e.tag = pend[0].tag; e.step = step_no;
            sb.push_back(e);
            void'(pend.pop_front());
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_out", 64'(out_tag), 64'hffff);
            end else begin
                e = sb.pop_front();
                check_eq($sformatf("sum_tag%0d", e.tag), 64'(out_sum), 64'(e.sum));
                check_eq($sformatf("z_tag%0d", e.tag), 64'(out_z), 64'(e.z));
                check_eq($sformatf("op_tag%0d", e.tag), 64'(out_opcode), 64'(e.op));
                check_eq("tag_order", 64'(out_tag), 64'(e.tag));
                last_lat = step_no - e.step;
            end
        end
        step_no++;
    endtask

    task automatic drain(input bit rnd);
        for (int i = 0; i < 300 && (sb.size() > 0 || pend.size() > 0); i++) begin
            step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        check_eq("drain_left", 64'(sb.size() + pend.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_sum", 64'(out_sum), 64'd0);
        check_eq("rst_out_z", 64'(out_z), 64'd0);
        check_eq("rst_out_opcode", 64'(out_opcode), 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        // Single beat: 2.0 + 1.0 with latency check
        add_stim(32'h40000000, 1'b0, 32'h40400000, 8'h5a);
        drain(1'b0);
        check_eq("latency", 64'(last_lat), 64'd5);

        // Directed specials, rounding and sign cases, back to back
        add_stim(32'h3f800000, 1'b1, 32'h00000000, 8'h10);
        add_stim(32'h7fc00001, 1'b0, 32'h7fc00000, 8'h11);
        add_stim(32'h7f800000, 1'b0, 32'h7f800000, 8'h12);
        add_stim(32'h4b800000, 1'b0, 32'h4b800000, 8'h13);
        add_stim(32'h7f7fffff, 1'b0, 32'h7f7fffff, 8'h14);
        add_stim(32'hff800000, 1'b0, 32'hff800000, 8'h15);
        add_stim(32'h7f800000, 1'b1, 32'h7f800000, 8'h16);
        add_stim(32'h00000001, 1'b0, 32'h3f800000, 8'h17);
        add_stim(32'h80000000, 1'b1, 32'hbf800000, 8'h18);
        add_stim(32'hbf800000, 1'b0, 32'h00000000, 8'h19);
        add_stim(32'h3f000000, 1'b1, 32'hbf000000, 8'h1a);
        add_stim(32'h4b800001, 1'b0, 32'h4b800002, 8'h1b);
        add_stim(32'h4bffffff, 1'b0, 32'h4c000000, 8'h1c);
        add_stim(32'h40000000, 1'b1, 32'h3f800000, 8'h1d);
        drain(1'b0);

        // Ten beats with a three-cycle downstream stall once full
        for (int k = 0; k < 10; k++) add_stim(i2f(k), 1'b0, i2f(k + 1), 8'(k));
        for (int i = 0; i < 20; i++) begin
            step(1'b1);
            if (out_valid) break;
        end
        check_eq("pipe_full", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check_eq("hold_in_ready", 64'(last_in_ready), 64'd0);
        end
        drain(1'b0);

        // Random stream under random backpressure
        for (int i = 0; i < 24; i++) begin
            int unsigned k;
            logic        s;
            k = $urandom_range(1, 200);
            s = 1'($urandom_range(0, 1));
            add_stim(i2f(k), s, s ? i2f(k - 1) : i2f(k + 1), 8'(8'h40 + i));
        end
        for (int i = 0; i < 40 && pend.size() > 0; i++) step(1'($urandom_range(0, 1)));
        drain(1'b1);

        // Reset with three beats in flight
        for (int k = 3; k < 6; k++) add_stim(i2f(k), 1'b0, i2f(k + 1), 8'(8'h80 + k));
        repeat (3) step(1'b1);
        @(negedge clock);
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_out_sum", 64'(out_sum), 64'd0);
        sb.delete();
        pend.delete();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) step(1'b1);
        add_stim(32'h40000000, 1'b0, 32'h40400000, 8'hc0);
        drain(1'b0);
        check_eq("post_rst_latency", 64'(last_lat), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/const_add_pipe.md
CONST_ADD_PIPE -- requirements
Module: const_add_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CONST_A, 32'h3f800000, IEEE-754 single-precision constant operand.
- PASS_W, 32, width of the sideband word carried alongside the sum.
- OP_W, 4, opcode width.
- TAG_W, 8, instruction tag width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock  in  1  single clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  pipeline accepts a beat this cycle.
- in_b  in  32  single-precision operand B.
- in_sub  in  1  0: result = B + CONST_A; 1: result = B - CONST_A.
- in_z  in  PASS_W  sideband word, passed through untouched.
- in_opcode  in  OP_W  opcode, passed through.
- in_tag  in  TAG_W  tag, passed through.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  32  single-precision result.
- out_z  out  PASS_W  sideband aligned with out_sum.
- out_opcode  out  OP_W  opcode aligned with out_sum.
- out_tag  out  TAG_W  tag aligned with out_sum.

Function
REQ-003 The block SHALL have five register stages: special-case detect, align, add, normalise, round/pack.
REQ-004 advance SHALL equal out_ready OR NOT out_valid; all stages SHALL shift only when advance is 1, otherwise hold.
REQ-005 in_ready SHALL equal advance; a beat SHALL be accepted when in_valid AND in_ready.
REQ-006 Latency SHALL be exactly 5 cycles from acceptance to out_valid with no stall; throughput SHALL be 1 beat per cycle.
REQ-007 Each stage SHALL carry a valid bit; bubbles SHALL propagate and SHALL NOT be reported on out_valid.
REQ-008 Beats SHALL leave in acceptance order; none SHALL be lost or duplicated under any out_ready pattern.
REQ-009 z, opcode and tag SHALL travel with their operand, unchanged.
REQ-010 Subtraction SHALL invert the sign of CONST_A before the add.
REQ-011 Denormal inputs SHALL be treated as signed zero.
REQ-012 Specials, in priority order:
- NaN on either operand -> 32'h7fc00000.
- +Inf + -Inf -> 32'h7fc00000.
- A single Inf -> that Inf.
- Zero operand -> the other operand, with +0 for (+0) + (-0).
REQ-013 Alignment SHALL shift the smaller mantissa right and keep guard, round and sticky bits (27-bit working mantissa, 28-bit sum).
REQ-014 Rounding SHALL be round-to-nearest-even; a carry out of rounding SHALL renormalise and increment the exponent.
REQ-015 Exponent above 254 after rounding SHALL give signed Inf; exponent below 1 SHALL give signed zero (flush).
REQ-016 An exact-zero difference SHALL give +0.

Reset
REQ-017 While reset_n is 0, all stage valid bits, out_valid, out_sum, out_z, out_opcode and out_tag SHALL be 0; in_ready SHALL be 1 after release.
REQ-018 Reset asserted mid-operation SHALL discard every in-flight beat; the first out_valid after release SHALL belong to a beat accepted after release.

Structure
REQ-019 Package hcordic_fp_pkg SHALL hold:
- float field widths and bias 127;
- QNAN and INF constants;
- a typedef for the per-stage sideband record (valid, z, opcode, tag).
REQ-020 Leading-zero count plus left shift SHALL be one sub-module, fp_normalise, instantiated in the normalise stage.

Verification
REQ-021 With in_b=32'h40000000, in_sub=0, out_ready=1: out_sum=32'h40400000 exactly 5 cycles after acceptance, tag and z echoed.
REQ-022 With in_b=32'h3f800000, in_sub=1: out_sum=32'h00000000; in_b=32'h7fc00001 -> 32'h7fc00000; in_b=32'h7f800000 -> 32'h7f800000.
REQ-023 Rounding: in_b=32'h4b800000 (2^24), sub=0 -> 32'h4b800000 (tie rounds to even); in_b=32'h7f7fffff -> 32'h7f7fffff.
REQ-024 Stream 10 beats, tags 0..9, and hold out_ready=0 for 3 cycles once the pipe is full: in_ready=0 during the hold, and all 10 beats exit in order with no loss.
REQ-025 Drop reset_n for 1 cycle with 3 beats in flight: out_valid=0 immediately and no stale beat emerges afterwards.
